rotate_fb_sched: RTL and testbench

triple-buffer scheduler for the rotation frame store; decides which buffer the writer fills and which the reader scans, per frame.

Interface
REQ-001 Parameter BUFSIZE, default 76800, words per buffer (WIDTH*HEIGHT).
REQ-002 Parameter AW, default 18, address width; 3*BUFSIZE SHALL be <= 2^AW.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 wr_vblank  in  1  writer-side vertical blank; rising edge = write frame complete.
REQ-006 rd_vblank  in  1  reader-side vertical blank; rising edge = read frame swap point.
REQ-007 freeze  in  1  high: completed write frames are not published.
REQ-008 wr_buf  out  2  buffer index being written.
REQ-009 rd_buf  out  2  buffer index being read.
REQ-010 wr_base  out  AW  wr_buf*BUFSIZE.
REQ-011 rd_base  out  AW  rd_buf*BUFSIZE.
REQ-012 wr_start  out  1  one-cycle pulse: writer reloads address from wr_base.
REQ-013 rd_start  out  1  one-cycle pulse: reader reloads address from rd_base.
REQ-014 drop_cnt  out  8  count of published frames overwritten before being read.
REQ-015 rep_cnt  out  8  count of reader swaps with no new frame (frame repeated).

Function
REQ-016 Internal state: wr_buf, rd_buf, spare_buf, pend (spare holds an unread completed frame).
REQ-017 {wr_buf, rd_buf, spare_buf} SHALL always be a permutation of {0,1,2}.
REQ-018 Edge detect: wr_end = wr_vblank & ~wr_vblank_q; rd_swap = rd_vblank & ~rd_vblank_q; _q are registered previous samples.
REQ-019 Latency: indices, bases, pulses, counters update at the same edge that samples the detected edge (one clock after input rise).
REQ-020 wr_end only, freeze=0: spare<=old wr, wr<=old spare, pend<=1; if pend was 1, drop_cnt++.
REQ-021 wr_end only, freeze=1: indices and pend unchanged; wr_start still pulses (writer rewrites same buffer).
REQ-022 rd_swap only, pend=1: rd<=old spare, spare<=old rd, pend<=0.
REQ-023 rd_swap only, pend=0: indices unchanged, rep_cnt++.
REQ-024 Simultaneous wr_end (freeze=0) and rd_swap: rd<=old wr, wr<=old spare, spare<=old rd, pend<=0; drop_cnt++ if pend was 1; rep_cnt unchanged.
REQ-025 Simultaneous wr_end (freeze=1) and rd_swap: apply REQ-022/023 only.
REQ-026 wr_start pulses on every wr_end; rd_start pulses on every rd_swap; otherwise 0.
REQ-027 Counters saturate at 255, never wrap.
REQ-028 wr_base/rd_base registered, always consistent with wr_buf/rd_buf in the same cycle; computed as index*BUFSIZE truncated to AW.
REQ-029 No handshake beyond edges; held-high vblank SHALL produce exactly one event.

Reset
REQ-030 reset_n low: wr_buf=0, rd_buf=1, spare_buf=2, pend=0, wr_base=0, rd_base=BUFSIZE, wr_start=0, rd_start=0, drop_cnt=0, rep_cnt=0, vblank _q registers=1 (no false edge if vblank high at release).
REQ-031 Reset asserted mid-frame SHALL return all state to REQ-030 values immediately, independent of clk.
REQ-032 First event after release requires a low-to-high transition observed post-reset.

Verification
REQ-033 Reset release, wr_vblank pulse -> wr_buf=2, spare=0, pend=1, wr_base=2*BUFSIZE, wr_start one cycle.
REQ-034 Then rd_vblank pulse -> rd_buf=0, rd_base=0, spare=1, pend=0, rd_start one cycle, rep_cnt=0.
REQ-035 Two wr_vblank pulses, no rd -> second sets drop_cnt=1; rd_vblank then selects last completed buffer.
REQ-036 wr_vblank and rd_vblank rising same cycle from reset state -> rd_buf=0, wr_buf=2, spare=1, pend=0.
REQ-037 freeze=1, 300 rd_vblank pulses without writes -> rep_cnt=255 saturated, indices unchanged; wr pulses give wr_start, no pend.
REQ-038 Assert reset_n low between clocks mid-sequence -> outputs at REQ-030 values before next edge; permutation check throughout random run.

---
 rtl/rotate_fb_sched.sv | 137 +++++++++++++
 tb/tb_rotate_fb_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rotate_fb_sched.sv
// Triple-buffer scheduler for the rotation frame store.
// Each frame it decides which buffer the writer fills and which buffer the reader scans.
// The third buffer (spare) holds the newest completed frame that nobody has read yet.
//
// Interface contract: there is no valid/ready handshake here. The only events are
// rising edges of wr_vblank (a write frame is complete) and rd_vblank (the reader
// swap point). A vblank held high gives exactly one event. wr_start and rd_start
// are one-cycle strobes that come out in the same cycle as the index update they
// announce. 3*BUFSIZE must fit in AW bits.
module rotate_fb_sched #(
  parameter int unsigned BUFSIZE = 76800,
  parameter int unsigned AW      = 18
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_vblank,
  input  logic          rd_vblank,
  input  logic          freeze,
  output logic [1:0]    wr_buf,
  output logic [1:0]    rd_buf,
  output logic [AW-1:0] wr_base,
  output logic [AW-1:0] rd_base,
  output logic          wr_start,
  output logic          rd_start,
  output logic [7:0]    drop_cnt,
  output logic [7:0]    rep_cnt,
  // debug view of the internal rotation state
  output logic [1:0]    spare_buf,
  output logic          pend
);

  localparam logic [AW-1:0] BASE1 = AW'(BUFSIZE);
  localparam logic [AW-1:0] BASE2 = AW'(2 * BUFSIZE);

  // Buffer index to base address, truncated to AW bits.
  function automatic logic [AW-1:0] base_of(input logic [1:0] idx);
    logic [AW-1:0] b;
    case (idx)
      2'd1:    b = BASE1;
      2'd2:    b = BASE2;
      default: b = '0;
    endcase
    return b;
  endfunction

  logic          wr_vblank_q, rd_vblank_q;
  logic [1:0]    wr_q, wr_d, rd_q, rd_d, spare_q, spare_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] wr_base_q, wr_base_d, rd_base_q, rd_base_d;
  logic          wr_start_q, wr_start_d, rd_start_q, rd_start_d;
  logic [7:0]    drop_q, drop_d, rep_q, rep_d;
  logic          wr_end, rd_swap, publish;

  assign wr_end  = wr_vblank & ~wr_vblank_q;
  assign rd_swap = rd_vblank & ~rd_vblank_q;
  // a completed write frame only becomes visible to the reader when not frozen
  assign publish = wr_end & ~freeze;

  // Next-state rotation of the three buffer indices, strobes and counters.
  always_comb begin
    wr_d       = wr_q;
    rd_d       = rd_q;
    spare_d    = spare_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    rep_d      = rep_q;
    wr_start_d = wr_end;
    rd_start_d = rd_swap;
    if (publish && rd_swap) begin
      // the frame just finished goes straight to the reader
      rd_d    = wr_q;
      wr_d    = spare_q;
      spare_d = rd_q;
      pend_d  = 1'b0;
      if (pend_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (publish) begin
      spare_d = wr_q;
      wr_d    = spare_q;
      pend_d  = 1'b1;
      if (pend_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (rd_swap) begin
      if (pend_q) begin
        rd_d    = spare_q;
        spare_d = rd_q;
        pend_d  = 1'b0;
      end else if (rep_q != 8'hFF) begin
        rep_d = rep_q + 8'd1;
      end
    end
    // bases follow the next indices so they agree with them every cycle
    wr_base_d = base_of(wr_d);
    rd_base_d = base_of(rd_d);
  end

  // State registers; vblank history resets high so a high level at release is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_vblank_q <= 1'b1;
      rd_vblank_q <= 1'b1;
      wr_q        <= 2'd0;
      rd_q        <= 2'd1;
      spare_q     <= 2'd2;
      pend_q      <= 1'b0;
      wr_base_q   <= '0;
      rd_base_q   <= BASE1;
      wr_start_q  <= 1'b0;
      rd_start_q  <= 1'b0;
      drop_q      <= 8'd0;
      rep_q       <= 8'd0;
    end else begin
      wr_vblank_q <= wr_vblank;
      rd_vblank_q <= rd_vblank;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      spare_q     <= spare_d;
      pend_q      <= pend_d;
      wr_base_q   <= wr_base_d;
      rd_base_q   <= rd_base_d;
      wr_start_q  <= wr_start_d;
      rd_start_q  <= rd_start_d;
      drop_q      <= drop_d;
      rep_q       <= rep_d;
    end
  end

  assign wr_buf    = wr_q;
  assign rd_buf    = rd_q;
  assign spare_buf = spare_q;
  assign pend      = pend_q;
  assign wr_base   = wr_base_q;
  assign rd_base   = rd_base_q;
  assign wr_start  = wr_start_q;
  assign rd_start  = rd_start_q;
  assign drop_cnt  = drop_q;
  assign rep_cnt   = rep_q;

endmodule

// File: tb/tb_rotate_fb_sched.sv
// Bench for rotate_fb_sched: a behavioural model pushes the expected state per cycle,
// and the DUT outputs are popped and compared one cycle later.
module tb_rotate_fb_sched;

  localparam int unsigned BUFSIZE = 76800;
  localparam int unsigned AW      = 18;
  localparam int          EW      = 25;

  logic          clk;
  logic          reset_n;
  logic          wr_vblank, rd_vblank, freeze;
  logic [1:0]    wr_buf, rd_buf, spare_buf;
  logic [AW-1:0] wr_base, rd_base;
  logic          wr_start, rd_start, pend;
  logic [7:0]    drop_cnt, rep_cnt;

  rotate_fb_sched #(.BUFSIZE(BUFSIZE), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_vblank (wr_vblank),
    .rd_vblank (rd_vblank),
    .freeze    (freeze),
    .wr_buf    (wr_buf),
    .rd_buf    (rd_buf),
    .wr_base   (wr_base),
    .rd_base   (rd_base),
    .wr_start  (wr_start),
    .rd_start  (rd_start),
    .drop_cnt  (drop_cnt),
    .rep_cnt   (rep_cnt),
    .spare_buf (spare_buf),
    .pend      (pend)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // expected {wr, rd, spare, pend, wr_start, rd_start, drop, rep}
  logic [EW-1:0] exp_q[$];

  logic [1:0] m_wr, m_rd, m_sp;
  logic       m_pend, m_wvq, m_rvq;
  logic [7:0] m_drop, m_rep;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_of(input logic [1:0] idx);
    logic [31:0] full;
    full = 32'(idx) * BUFSIZE;
    return full & ((32'd1 << AW) - 32'd1);
  endfunction

  task automatic model_reset();
    m_wr = 2'd0; m_rd = 2'd1; m_sp = 2'd2;
    m_pend = 1'b0; m_drop = 8'd0; m_rep = 8'd0;
    m_wvq = 1'b1; m_rvq = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_wr"},    32'(wr_buf), 32'd0);
    chk({pfx, "_rd"},    32'(rd_buf), 32'd1);
    chk({pfx, "_sp"},    32'(spare_buf), 32'd2);
    chk({pfx, "_pend"},  32'(pend), 32'd0);
    chk({pfx, "_wbase"}, 32'(wr_base), 32'd0);
    chk({pfx, "_rbase"}, 32'(rd_base), BUFSIZE);
    chk({pfx, "_wst"},   32'(wr_start), 32'd0);
    chk({pfx, "_rst"},   32'(rd_start), 32'd0);
    chk({pfx, "_drop"},  32'(drop_cnt), 32'd0);
    chk({pfx, "_rep"},   32'(rep_cnt), 32'd0);
  endtask

  // One clock: drive inputs, advance the model, push expectation, then compare after the edge.
  task automatic cycle(input logic wv, input logic rv, input logic fz);
    logic we, rs;
    logic [1:0] o_wr, o_rd, o_sp;
    logic [EW-1:0] e;
    wr_vblank = wv; rd_vblank = rv; freeze = fz;
    we = wv & ~m_wvq;
    rs = rv & ~m_rvq;
    m_wvq = wv; m_rvq = rv;
    o_wr = m_wr; o_rd = m_rd; o_sp = m_sp;
    if (we && !fz && rs) begin
      m_rd = o_wr; m_wr = o_sp; m_sp = o_rd;
      if (m_pend && m_drop != 8'hFF) m_drop++;
      m_pend = 1'b0;
    end else if (we && !fz) begin
      m_sp = o_wr; m_wr = o_sp;
      if (m_pend && m_drop != 8'hFF) m_drop++;
      m_pend = 1'b1;
    end else if (rs) begin
      if (m_pend) begin
        m_rd = o_sp; m_sp = o_rd; m_pend = 1'b0;
      end else if (m_rep != 8'hFF) begin
        m_rep++;
      end
    end
    exp_q.push_back({m_wr, m_rd, m_sp, m_pend, we, rs, m_drop, m_rep});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("wr_buf",   32'(wr_buf),    32'(e[24:23]));
      chk("rd_buf",   32'(rd_buf),    32'(e[22:21]));
      chk("spare",    32'(spare_buf), 32'(e[20:19]));
      chk("pend",     32'(pend),      32'(e[18]));
      chk("wr_start", 32'(wr_start),  32'(e[17]));
      chk("rd_start", 32'(rd_start),  32'(e[16]));
      chk("drop_cnt", 32'(drop_cnt),  32'(e[15:8]));
      chk("rep_cnt",  32'(rep_cnt),   32'(e[7:0]));
      chk("wr_base",  32'(wr_base),   base_of(e[24:23]));
      chk("rd_base",  32'(rd_base),   base_of(e[22:21]));
    end
    chk("perm", (32'd1 << wr_buf) | (32'd1 << rd_buf) | (32'd1 << spare_buf), 32'd7);
  endtask

  // Called at posedge+1: asserts reset between edges and checks outputs before the next edge.
  task automatic async_reset(input string pfx);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs(pfx);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_vblank = 1'b1; rd_vblank = 1'b0; freeze = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // vblank held high across release: no event
    cycle(1, 0, 0);
    chk("held_no_wst", 32'(wr_start), 32'd0);
    cycle(0, 0, 0);

    // first write frame completes
    cycle(1, 0, 0);
    chk("w1_wr", 32'(wr_buf), 32'd2);
    chk("w1_sp", 32'(spare_buf), 32'd0);
    chk("w1_pend", 32'(pend), 32'd1);
    chk("w1_wbase", 32'(wr_base), 2 * BUFSIZE);
    chk("w1_wst", 32'(wr_start), 32'd1);
    cycle(1, 0, 0);
    chk("w1_wst_end", 32'(wr_start), 32'd0);
    cycle(0, 0, 0);

    // reader picks it up
    cycle(0, 1, 0);
    chk("r1_rd", 32'(rd_buf), 32'd0);
    chk("r1_rbase", 32'(rd_base), 32'd0);
    chk("r1_sp", 32'(spare_buf), 32'd1);
    chk("r1_pend", 32'(pend), 32'd0);
    chk("r1_rst", 32'(rd_start), 32'd1);
    chk("r1_rep", 32'(rep_cnt), 32'd0);
    cycle(0, 0, 0);

    // two writes without a read: one dropped, reader gets the latest
    cycle(1, 0, 0); cycle(0, 0, 0);
    cycle(1, 0, 0); cycle(0, 0, 0);
    chk("dr_drop", 32'(drop_cnt), 32'd1);
    cycle(0, 1, 0); cycle(0, 0, 0);
    chk("dr_rd", 32'(rd_buf), 32'd1);

    // simultaneous edges from the reset state
    async_reset("ar1");
    cycle(0, 0, 0);
    cycle(1, 1, 0);
    chk("sim_rd", 32'(rd_buf), 32'd0);
    chk("sim_wr", 32'(wr_buf), 32'd2);
    chk("sim_sp", 32'(spare_buf), 32'd1);
    chk("sim_pend", 32'(pend), 32'd0);
    cycle(0, 0, 0);

    // frozen: 300 reader swaps saturate the repeat counter
    async_reset("ar2");
    for (int i = 0; i < 300; i++) begin
      cycle(0, 1, 1);
      cycle(0, 0, 1);
    end
    chk("sat_rep", 32'(rep_cnt), 32'd255);
    chk("sat_wr", 32'(wr_buf), 32'd0);
    chk("sat_rd", 32'(rd_buf), 32'd1);
    cycle(1, 0, 1);
    chk("frz_wst", 32'(wr_start), 32'd1);
    chk("frz_pend", 32'(pend), 32'd0);
    chk("frz_wr", 32'(wr_buf), 32'd0);
    cycle(0, 0, 1);

    // random traffic with a mid-run reset
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    async_reset("ar3");
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
